// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default bit timing.
package uart_pkg;

    // 115200 baud from a 100 MHz pclk
    localparam int DEF_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit. Held at zero while clear is high so every frame starts
// on a full bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic pclk,
    input  logic prstn,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = enable && (cnt_q == LAST);

    // Next count: restart at each bit boundary so no bit drifts
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: accepts a byte on a valid/ready handshake and serialises
// it as start, data (LSB first), optional parity and 1-2 stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           pclk,
    input  logic           prstn,
    uart_tx_ctrl_if.slave  bus,
    output logic           txd,
    output logic           busy,
    output logic           tx_done
);
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    // Seeding the running parity with 1 turns the XOR into odd parity
    localparam logic PAR_INIT = (PARITY_ODD != 0);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;
    logic                  accept;

    assign bus.tx_ready = (state_q == IDLE);
    assign accept       = (state_q == IDLE) && bus.tx_valid;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .pclk    (pclk),
        .prstn   (prstn),
        .clear   (state_q == IDLE),
        .enable  (state_q != IDLE),
        .bit_end (bit_end)
    );

    // State register; reset aborts any frame in flight
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: advance one frame field per completed bit period
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.tx_valid) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && bit_cnt_q == LAST_DATA)
                         state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end && bit_cnt_q == LAST_STOP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture, shift, running parity, bit index
    always_comb begin
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shift_d = bus.tx_data;
            par_d   = PAR_INIT;
        end else if (state_q == DATA && bit_end) begin
            shift_d = shift_q >> 1;
            par_d   = par_q ^ shift_q[0];
        end
        if (state_d != state_q)
            bit_cnt_d = '0;
        else if (bit_end)
            bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // Output decode from the upcoming state so txd changes with the state
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    // Datapath and registered line outputs
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
endmodule
